// File: rtl/des_key_schedule.sv
// DES round-key generator: PC-1 on load, then one PC-2 subkey per handshake,
// forward (K1..K16) for encrypt or reverse (K16..K1) for decrypt.
module des_key_schedule #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        last
);

    typedef enum logic {IDLE, GEN} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Bit p set: stepping into emission position p is a 1-bit rotation, else 2.
    // Left (encrypt) and right (decrypt) schedules coincide for positions 1..15.
    localparam logic [15:0] SINGLE_STEP = 16'b1000_0001_0000_0010;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return r;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;

    logic [55:0] cd0;
    logic [3:0]  round_nx;
    logic        step_two;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        d_d      = d_q;
        round_d  = round_q;
        dec_d    = dec_q;
        cd0      = pc1(key_in);
        round_nx = round_q + 4'd1;
        step_two = ~SINGLE_STEP[round_nx];

        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    dec_d   = decrypt;
                    round_d = '0;
                    state_d = GEN;
                    // Decrypt starts from C0/D0, which equals C16/D16.
                    c_d     = decrypt ? cd0[55:28] : rol28(cd0[55:28], 1'b0);
                    d_d     = decrypt ? cd0[27:0]  : rol28(cd0[27:0],  1'b0);
                end
            end
            GEN: begin
                if (sk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = IDLE;
                        round_d = '0;
                    end else begin
                        round_d = round_nx;
                        c_d     = dec_q ? ror28(c_q, step_two) : rol28(c_q, step_two);
                        d_d     = dec_q ? ror28(d_q, step_two) : rol28(d_q, step_two);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_ready = (state_q == IDLE);
    assign sk_valid  = (state_q == GEN);
    assign subkey    = sk_valid ? pc2({c_q, d_q}) : '0;
    assign round     = round_q;
    assign last      = sk_valid && (round_q == LAST_ROUND);

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
Sequential DES round-key generator that feeds the key-mixing stage directly upstream of the S-box bank. It accepts a 64-bit key, applies PC-1, then emits one 48-bit PC-2 subkey per accepted handshake for 16 rounds. Encrypt mode emits K1..K16; decrypt mode emits K16..K1. The downstream expansion/XOR stage consumes each subkey and forms the 6-bit S-box inputs.

Parameters:
NUM_ROUNDS, 16, subkeys emitted per key load; fixed at 16 for DES, exposed only for bench visibility.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  key_in/decrypt valid.
key_ready  output  1  block idle; key load accepted when key_valid & key_ready.
key_in  input  64  DES key; DES bit 1 = key_in[63]; parity bits (DES 8,16,..,64) ignored.
decrypt  input  1  sampled with key; 0 = K1..K16 order, 1 = K16..K1 order.
sk_valid  output  1  subkey valid.
sk_ready  input  1  consumer accepts subkey when sk_valid & sk_ready.
subkey  output  48  current round key; DES PC-2 bit 1 = subkey[47].
round  output  4  index of current subkey in emission order, 0..15.
last  output  1  high with sk_valid when round == 15.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all state returns to IDLE.
- Reset values: key_ready=1, sk_valid=0, subkey=0, round=0, last=0; C/D registers = 0.
- State machine has two states, IDLE and GEN.
- IDLE:
  - key_ready=1, sk_valid=0.
  - On key_valid & key_ready: latch decrypt and split PC-1(key_in) into C0/D0 (28 bits each).
  - Encrypt: load C/D rotated left by 1, giving C1/D1.
  - Decrypt: load C0/D0 unrotated, since C16/D16 = C0/D0.
  - Set round=0 and go to GEN.
  - Latency: sk_valid rises the cycle after the load handshake.
- GEN:
  - key_ready=0; key_valid is ignored and no load is accepted.
  - subkey = PC-2(C,D), driven combinationally from the C/D registers.
  - On each sk_valid & sk_ready with round < 15: round increments and C/D rotate once, at most one rotation step per cycle.
  - Encrypt rotates left by shift[round+1]; left shift schedule for rounds 1..16 is 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt rotates right by rshift[round+1]; rshift for emission positions 0..15 is 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - On handshake with round == 15: go to IDLE next cycle, with sk_valid=0, key_ready=1, round=0.
  - Back-pressure: while sk_valid=1 and sk_ready=0, subkey, round and last hold stable; no rotation occurs.
- subkey is forced to 0 whenever sk_valid=0.
- Throughput: with sk_ready tied high, 16 subkeys on 16 consecutive cycles. Next load is accepted earliest on the cycle after the final handshake, so there is a 1 idle cycle between key sets.
- Reset asserted mid-GEN: outputs take reset values immediately (asynchronously). The partial sequence is discarded; no resume.
- After a full sequence, C/D end at C16/D16 (encrypt) or C0-based values (decrypt). These are don't-care in IDLE.

Test Plan:
- Encrypt: key 0x133457799BBCDFF1, decrypt=0, sk_ready=1.
  - sk_valid rises 1 cycle after load.
  - round0 subkey=0x1B02EFFC7072, round1 subkey=0x79AED9DBC9E5, round15 subkey=0xCB3D8B0E17F5 with last=1.
  - Exactly 16 valid cycles, then key_ready=1.
- Decrypt: same key, decrypt=1.
  - round0 subkey=0xCB3D8B0E17F5, round15 subkey=0x1B02EFFC7072 with last=1.
  - The full sequence equals the encrypt sequence reversed.
- Back-pressure: encrypt run with sk_ready randomly low, including ≥3 consecutive low cycles at round 1 and round 15.
  - subkey/round/last are stable while stalled.
  - Emitted sequence is identical to the unstalled run.
- Load during GEN: pulse key_valid with key 0xFFFFFFFFFFFFFFFF and decrypt=1 at round 5.
  - key_ready stays 0; the sequence is unaffected.
- Reset mid-operation: assert rst_n=0 at round 7 between clock edges.
  - sk_valid=0, subkey=0, round=0, key_ready=1 immediately.
  - After release, a new load of 0x133457799BBCDFF1 reproduces the encrypt sequence from round 0.
- Back-to-back: hold key_valid=1 continuously, alternating decrypt 0/1.
  - Each load is accepted on the cycle key_ready=1.
  - Sequences alternate forward/reverse with exactly one idle cycle between them.
